// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue front-end.
// Holds the packed instruction layout, the func code values and the helper
// that tells unary ops (which ignore rs2) apart from binary ones.
package alu_pkg;

    localparam int INSTR_W = 25;
    localparam int REG_W   = 4;
    localparam int FUNC_W  = 4;
    localparam int ADDR_W  = 8;

    // Field order matches the instruction word, MSB first:
    // [24] write, [23:20] func, [19:16] rd, [15:12] rs1, [11:8] rs2, [7:0] addr
    typedef struct packed {
        logic              write;
        logic [FUNC_W-1:0] func;
        logic [REG_W-1:0]  rd;
        logic [REG_W-1:0]  rs1;
        logic [REG_W-1:0]  rs2;
        logic [ADDR_W-1:0] addr;
    } instr_t;

    localparam logic [FUNC_W-1:0] FN_ADD = 4'd0;
    localparam logic [FUNC_W-1:0] FN_SUB = 4'd1;
    localparam logic [FUNC_W-1:0] FN_MUL = 4'd2;
    localparam logic [FUNC_W-1:0] FN_AND = 4'd5;
    localparam logic [FUNC_W-1:0] FN_OR  = 4'd6;
    localparam logic [FUNC_W-1:0] FN_XOR = 4'd7;
    localparam logic [FUNC_W-1:0] FN_NOT = 4'd8;
    localparam logic [FUNC_W-1:0] FN_SHL = 4'd11;

    // Every code from NOT upwards is single-operand, so rs2 carries no dependency.
    function automatic logic is_unary(input logic [FUNC_W-1:0] func);
        return (func >= FN_NOT);
    endfunction

endpackage

// File: rtl/alu_issue_unit_if.sv
// Instruction push channel into the issue unit (valid/ready).
//   in_valid : producer has an instruction
//   in_ready : issue unit can accept one this cycle
//   in_instr : packed instruction word (layout in alu_pkg::instr_t)
interface alu_issue_unit_if;
    import alu_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic [INSTR_W-1:0] in_instr;

    modport master (output in_valid, output in_instr, input in_ready);
    modport slave  (input in_valid, input in_instr, output in_ready);

endinterface

// File: rtl/issue_fifo.sv
// Synchronous FIFO with registered occupancy.
//   clk, rst      : clock, synchronous active-high reset
//   push, wdata   : write request / data (ignored while full)
//   pop           : read request (ignored while empty)
//   rdata         : current head entry
//   count         : occupancy, full, empty derived from it
module issue_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 25
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_INC = PTR_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_INC = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             push_s;
    logic             pop_s;

    // Full/empty come from the registered count, so a pop never frees a slot
    // for a push in the same cycle.
    assign full   = (count_r == CNT_MAX);
    assign empty  = (count_r == {CNT_W{1'b0}});
    assign push_s = push && !full;
    assign pop_s  = pop && !empty;
    assign rdata  = mem_r[rd_ptr_r];
    assign count  = count_r;

    // Storage write; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_INC;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_INC;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_INC;
                2'b01:   count_r <= count_r - CNT_INC;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/alu_issue_unit.sv
// Issue front-end for the 4-stage ALU pipeline.
// Buffers instructions in a FIFO, holds the head while a source register is
// still owned by an in-flight instruction, and drives the pipeline's
// instruction inputs from registers, one instruction (or bubble) per cycle.
//   clk, rst          : clock, synchronous active-high reset
//   in_if (slave)     : in_valid / in_ready / in_instr push channel
//   iss_valid         : outputs carry a real instruction (0 = NOP bubble)
//   rs1,rs2,rd,func   : register/op fields to the pipeline
//   addr, write       : memory address / write enable to the pipeline
//   fifo_count        : FIFO occupancy
//   stall_cnt         : saturating count of hazard-stalled cycles
module alu_issue_unit
    import alu_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int HAZ_CYCLES = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    alu_issue_unit_if.slave        in_if,
    output logic                   iss_valid,
    output logic [REG_W-1:0]       rs1,
    output logic [REG_W-1:0]       rs2,
    output logic [REG_W-1:0]       rd,
    output logic [FUNC_W-1:0]      func,
    output logic [ADDR_W-1:0]      addr,
    output logic                   write,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic [15:0]            stall_cnt
);

    instr_t           head_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic             push_s;
    logic             hazard_s;
    logic             issue_s;
    logic             stall_s;

    logic             sb_valid_r [HAZ_CYCLES];
    logic [REG_W-1:0] sb_rd_r    [HAZ_CYCLES];
    instr_t           out_r;
    logic             iss_valid_r;
    logic [15:0]      stall_cnt_r;

    // Ready is withheld during reset so nothing is accepted while clearing.
    assign in_if.in_ready = !rst && !fifo_full_s;
    assign push_s         = in_if.in_valid && in_if.in_ready;

    issue_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (INSTR_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .wdata (in_if.in_instr),
        .pop   (issue_s),
        .rdata (head_s),
        .count (fifo_count),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // RAW check of the head's sources against every in-flight destination.
    always_comb begin
        hazard_s = 1'b0;
        for (int i = 0; i < HAZ_CYCLES; i++) begin
            if (sb_valid_r[i] && ((sb_rd_r[i] == head_s.rs1) ||
                (!is_unary(head_s.func) && (sb_rd_r[i] == head_s.rs2)))) begin
                hazard_s = 1'b1;
            end else begin
                hazard_s = hazard_s;
            end
        end
    end

    assign issue_s = !fifo_empty_s && !hazard_s;
    assign stall_s = !fifo_empty_s && hazard_s;

    // Scoreboard shift register: a slot ages one step per cycle until write-back.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < HAZ_CYCLES; i++) begin
                sb_valid_r[i] <= 1'b0;
                sb_rd_r[i]    <= 4'd0;
            end
        end else begin
            sb_valid_r[0] <= issue_s;
            sb_rd_r[0]    <= issue_s ? head_s.rd : 4'd0;
            for (int i = 1; i < HAZ_CYCLES; i++) begin
                sb_valid_r[i] <= sb_valid_r[i-1];
                sb_rd_r[i]    <= sb_rd_r[i-1];
            end
        end
    end

    // Pipeline output registers; a non-issue cycle registers an all-zero bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            iss_valid_r <= 1'b0;
            out_r       <= '{default: '0};
        end else if (issue_s) begin
            iss_valid_r <= 1'b1;
            out_r       <= head_s;
        end else begin
            iss_valid_r <= 1'b0;
            out_r       <= '{default: '0};
        end
    end

    // Saturating stall counter; an empty FIFO is idle, not stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_r <= 16'd0;
        end else if (stall_s && (stall_cnt_r != 16'hFFFF)) begin
            stall_cnt_r <= stall_cnt_r + 16'd1;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign iss_valid = iss_valid_r;
    assign rs1       = out_r.rs1;
    assign rs2       = out_r.rs2;
    assign rd        = out_r.rd;
    assign func      = out_r.func;
    assign addr      = out_r.addr;
    assign write     = out_r.write;
    assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_alu_issue_unit.sv
// Bench for alu_issue_unit: a queue/busy-until model tracks what the
// pipeline outputs must be each cycle; directed scenarios add literal checks.
module tb_alu_issue_unit;
    import alu_pkg::*;

    localparam int DEPTH = 4;
    localparam int HAZ   = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        iss_valid;
    logic [3:0]  rs1, rs2, rd, func;
    logic [7:0]  addr;
    logic        write;
    logic [$clog2(DEPTH):0] fifo_count;
    logic [15:0] stall_cnt;

    always #5 clk = ~clk;

    alu_issue_unit_if bus ();

    alu_issue_unit #(.DEPTH(DEPTH), .HAZ_CYCLES(HAZ)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_if      (bus),
        .iss_valid  (iss_valid),
        .rs1        (rs1),
        .rs2        (rs2),
        .rd         (rd),
        .func       (func),
        .addr       (addr),
        .write      (write),
        .fifo_count (fifo_count),
        .stall_cnt  (stall_cnt)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [24:0] mk(input logic w, input logic [3:0] f, input logic [3:0] d,
                                       input logic [3:0] a1, input logic [3:0] b1, input logic [7:0] ad);
        return {w, f, d, a1, b1, ad};
    endfunction

    // Model: in-order queue plus the edge at which each register becomes free.
    logic [24:0] mq [$];
    int          busy_until [16];
    int          t = 0;
    bit          started = 1'b0;
    logic        exp_valid, exp_write;
    logic [3:0]  exp_rs1, exp_rs2, exp_rd, exp_func;
    logic [7:0]  exp_addr;
    int          exp_count = 0;
    int          exp_stall = 0;
    int          iss_log [$];

    task automatic model_edge(input logic r, input logic v, input logic [24:0] ins);
        logic [24:0] h;
        logic        haz;
        logic        ready;
        {exp_valid, exp_write, exp_rs1, exp_rs2, exp_rd, exp_func, exp_addr} = '0;
        if (r) begin
            mq.delete();
            for (int i = 0; i < 16; i++) busy_until[i] = 0;
            exp_stall = 0;
        end else begin
            ready = (mq.size() != DEPTH);
            if (mq.size() > 0) begin
                h   = mq[0];
                haz = (t < busy_until[h[15:12]]) || ((h[23:20] < 4'd8) && (t < busy_until[h[11:8]]));
                if (haz) begin
                    if (exp_stall < 65535) exp_stall++;
                end else begin
                    void'(mq.pop_front());
                    exp_valid = 1'b1;
                    exp_write = h[24];
                    exp_func  = h[23:20];
                    exp_rd    = h[19:16];
                    exp_rs1   = h[15:12];
                    exp_rs2   = h[11:8];
                    exp_addr  = h[7:0];
                    busy_until[h[19:16]] = t + HAZ + 1;
                end
            end
            if (v && ready) mq.push_back(ins);
        end
        exp_count = mq.size();
        t++;
    endtask

    task automatic step(input logic r, input logic v, input logic [24:0] ins);
        rst          = r;
        bus.in_valid = v;
        bus.in_instr = ins;
        @(posedge clk);
        model_edge(r, v, ins);
        started = 1'b1;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 25'd0);
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (started) begin
            check("iss_valid", iss_valid, exp_valid);
            check("write", write, exp_write);
            check("rs1", rs1, exp_rs1);
            check("rs2", rs2, exp_rs2);
            check("rd", rd, exp_rd);
            check("func", func, exp_func);
            check("addr", addr, exp_addr);
            check("fifo_count", fifo_count, exp_count);
            check("stall_cnt", stall_cnt, exp_stall);
            check("in_ready", bus.in_ready, (!rst && (exp_count != DEPTH)) ? 32'd1 : 32'd0);
            if (iss_valid === 1'b1) iss_log.push_back(int'(rd));
        end
    end

    logic [24:0] lst [7];
    logic [4:0]  pat;
    int          k, accepts;
    bit          drop_seen;

    initial begin
        bus.in_valid = 1'b0;
        bus.in_instr = 25'd0;

        // Reset held with valid asserted
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, mk(1'b1, 4'd0, 4'd3, 4'd1, 4'd2, 8'hAA));
        check("rst_in_ready", bus.in_ready, 32'd0);
        check("rst_iss_valid", iss_valid, 32'd0);
        check("rst_write", write, 32'd0);
        check("rst_fifo_count", fifo_count, 32'd0);
        rst = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        check("rel_in_ready", bus.in_ready, 32'd1);

        // Independent stream: 1,1,1 starting one cycle after first accept
        step(1'b0, 1'b1, mk(1'b0, 4'd0, 4'd3, 4'd1, 4'd2, 8'h10));
        check("stream_first_bubble", iss_valid, 32'd0);
        step(1'b0, 1'b1, mk(1'b0, 4'd6, 4'd7, 4'd1, 4'd2, 8'h20));
        check("stream_add_valid", iss_valid, 32'd1);
        check("stream_add_rd", rd, 32'd3);
        step(1'b0, 1'b1, mk(1'b1, 4'd7, 4'd8, 4'd1, 4'd2, 8'h30));
        check("stream_or_rd", rd, 32'd7);
        step(1'b0, 1'b0, 25'd0);
        check("stream_xor_rd", rd, 32'd8);
        check("stream_xor_addr", addr, 32'h30);
        check("stream_xor_write", write, 32'd1);
        step(1'b0, 1'b0, 25'd0);
        check("stream_end_bubble", iss_valid, 32'd0);
        check("stream_stall", stall_cnt, 32'd0);
        idle(4);

        // RAW hazard: 1,0,0,0,1 and three stall cycles
        pat = 5'd0;
        step(1'b0, 1'b1, mk(1'b0, 4'd0, 4'd3, 4'd1, 4'd2, 8'h00));
        step(1'b0, 1'b1, mk(1'b0, 4'd1, 4'd4, 4'd3, 4'd1, 8'h00));
        pat = {pat[3:0], iss_valid};
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 25'd0);
            pat = {pat[3:0], iss_valid};
        end
        check("raw_pattern", pat, 32'b10001);
        check("raw_stall", stall_cnt, 32'd3);
        check("raw_sub_rd", rd, 32'd4);
        idle(4);

        // Unary op ignores rs2 even when it names the busy register
        step(1'b0, 1'b1, mk(1'b0, 4'd0, 4'd3, 4'd1, 4'd2, 8'h00));
        step(1'b0, 1'b1, mk(1'b0, 4'd8, 4'd9, 4'd1, 4'd3, 8'h00));
        step(1'b0, 1'b0, 25'd0);
        check("unary_valid", iss_valid, 32'd1);
        check("unary_rd", rd, 32'd9);
        check("unary_func", func, 32'd8);
        check("unary_stall", stall_cnt, 32'd3);
        idle(4);

        // FIFO full behind a stalled head, then wrap-around ordering
        lst[0] = mk(1'b0, 4'd0, 4'd3,  4'd1, 4'd2, 8'h01);
        lst[1] = mk(1'b0, 4'd1, 4'd4,  4'd3, 4'd1, 8'h02);
        lst[2] = mk(1'b0, 4'd5, 4'd5,  4'd4, 4'd2, 8'h03);
        lst[3] = mk(1'b0, 4'd0, 4'd10, 4'd1, 4'd2, 8'h04);
        lst[4] = mk(1'b0, 4'd6, 4'd11, 4'd1, 4'd2, 8'h05);
        lst[5] = mk(1'b1, 4'd7, 4'd12, 4'd1, 4'd2, 8'h06);
        lst[6] = mk(1'b0, 4'd2, 4'd13, 4'd1, 4'd2, 8'h07);
        iss_log.delete();
        k = 0;
        accepts = 0;
        drop_seen = 1'b0;
        for (int cyc = 0; cyc < 40 && k < 7; cyc++) begin
            if (bus.in_ready === 1'b1) begin
                step(1'b0, 1'b1, lst[k]);
                k++;
                accepts++;
            end else begin
                if (!drop_seen) begin
                    drop_seen = 1'b1;
                    check("full_accepts", accepts, 32'd5);
                    check("full_count", fifo_count, 32'd4);
                end
                step(1'b0, 1'b1, lst[k]);
            end
        end
        check("full_all_accepted", k, 32'd7);
        check("full_drop_seen", drop_seen, 32'd1);
        idle(12);
        check("order_len", iss_log.size(), 32'd7);
        if (iss_log.size() == 7) begin
            check("order_0", iss_log[0], 32'd3);
            check("order_1", iss_log[1], 32'd4);
            check("order_2", iss_log[2], 32'd5);
            check("order_3", iss_log[3], 32'd10);
            check("order_4", iss_log[4], 32'd11);
            check("order_5", iss_log[5], 32'd12);
            check("order_6", iss_log[6], 32'd13);
        end

        // Reset with entries queued and scoreboard busy
        step(1'b0, 1'b1, mk(1'b0, 4'd0, 4'd3, 4'd1, 4'd2, 8'h00));
        step(1'b0, 1'b1, mk(1'b0, 4'd1, 4'd4, 4'd3, 4'd1, 8'h00));
        step(1'b0, 1'b1, mk(1'b0, 4'd2, 4'd5, 4'd3, 4'd3, 8'h00));
        step(1'b0, 1'b1, mk(1'b0, 4'd1, 4'd6, 4'd3, 4'd1, 8'h00));
        check("mid_count_before", fifo_count, 32'd3);
        step(1'b1, 1'b0, 25'd0);
        rst = 1'b0;
        #1;
        check("mid_count_after", fifo_count, 32'd0);
        check("mid_stall_after", stall_cnt, 32'd0);
        check("mid_ready_after", bus.in_ready, 32'd1);
        step(1'b0, 1'b1, mk(1'b0, 4'd0, 4'd7, 4'd3, 4'd3, 8'h42));
        step(1'b0, 1'b0, 25'd0);
        check("mid_dep_valid", iss_valid, 32'd1);
        check("mid_dep_rd", rd, 32'd7);
        check("mid_dep_stall", stall_cnt, 32'd0);
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
